// File: rtl/mem_pkg.sv
// mem_pkg: size encodings, arbiter FSM states and default starvation limit shared by mem_arbiter
package mem_pkg;
  localparam logic [1:0] WW = 2'b00;
  localparam logic [1:0] WH = 2'b01;
  localparam logic [1:0] WB = 2'b10;
  localparam int STARVE_LIMIT_DEF = 4;
  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;
endpackage

// File: rtl/load_extend.sv
// load_extend: sign- or zero-extends the byte, half or word at the low end of a memory word
module load_extend import mem_pkg::*; #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  input  logic [DATA_WIDTH-1:0] i_word,
  output logic [DATA_WIDTH-1:0] o_data
);
  logic w_bsign, w_hsign;
  always_comb begin
    w_bsign = ~i_unsigned & i_word[7];
    w_hsign = ~i_unsigned & i_word[15];
    o_data = i_size == WW ? i_word :
             i_size == WH ? {{(DATA_WIDTH-16){w_hsign}}, i_word[15:0]} :
                            {{(DATA_WIDTH-8){w_bsign}}, i_word[7:0]};
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch/data arbiter for one memory port with starvation guard; MEM_ARB_ALIGN_CHECK_EN blocks misaligned accesses and raises Err
module mem_arbiter import mem_pkg::*; #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int STARVE_LIMIT  = STARVE_LIMIT_DEF
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     I_Req,
  input  logic [ADDRESS_WIDTH-1:0] I_Addr,
  output logic                     I_Ack,
  output logic [DATA_WIDTH-1:0]    I_Data,
  input  logic                     D_Req,
  input  logic                     D_WE,
  input  logic [1:0]               D_Size,
  input  logic                     D_Unsigned,
  input  logic [ADDRESS_WIDTH-1:0] D_Addr,
  input  logic [DATA_WIDTH-1:0]    D_WData,
  output logic                     D_Ack,
  output logic [DATA_WIDTH-1:0]    D_RData,
  output logic [ADDRESS_WIDTH-1:0] M_Addr,
  output logic [DATA_WIDTH-1:0]    M_Data,
  output logic                     M_W_EN,
  output logic [1:0]               M_sel,
  input  logic [DATA_WIDTH-1:0]    M_RData,
  output logic                     Err
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  state_t r_state, w_next;
  logic [CW-1:0] r_starve;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata, w_ext;
  logic [1:0] r_size;
  logic r_we, r_uns, r_is_d;
  logic w_idle, w_grant_i, w_grant_d, w_do, w_misalign;

  assign M_Addr = r_addr;
  assign M_Data = r_wdata;
  assign M_sel  = r_size;

  // r_size already holds the normalised size (fetch = word, 11 = byte)
`ifdef MEM_ARB_ALIGN_CHECK_EN
  logic r_err;
  assign w_misalign = r_size == WW ? |r_addr[1:0] : (r_size == WH) & r_addr[0];
  assign Err = r_err;
  always_ff @(posedge CLK) r_err <= RST & (r_state == ACCESS) & w_misalign;
`else
  assign w_misalign = 1'b0;
  assign Err = 1'b0;
`endif

  load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_ext (
    .i_size(r_size),
    .i_unsigned(r_uns),
    .i_word(M_RData),
    .o_data(w_ext)
  );

  always_comb begin
    w_idle = r_state == IDLE;
    w_grant_i = w_idle & I_Req & (~D_Req | (r_starve == CW'(STARVE_LIMIT)));
    w_grant_d = w_idle & D_Req & ~w_grant_i;
    w_next = w_idle & (I_Req | D_Req) ? ACCESS : IDLE;
    w_do = ~w_idle & ~w_misalign;
    M_W_EN = w_do & r_we & RST;
  end

  always_ff @(posedge CLK) r_state <= !RST ? IDLE : w_next;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_starve <= '0;
      r_addr <= '0;
      r_wdata <= '0;
      r_size <= '0;
      r_we <= 1'b0;
      r_uns <= 1'b0;
      r_is_d <= 1'b0;
      I_Ack <= 1'b0;
      D_Ack <= 1'b0;
      I_Data <= '0;
      D_RData <= '0;
    end else begin
      I_Ack <= ~w_idle & ~r_is_d;
      D_Ack <= ~w_idle & r_is_d;
      if (w_do & ~r_is_d) I_Data <= M_RData;
      if (w_do & r_is_d & ~r_we) D_RData <= w_ext;
      if (w_idle)
        r_starve <= (w_grant_i | ~I_Req) ? '0 :
                    (w_grant_d & (r_starve != CW'(STARVE_LIMIT))) ? r_starve + 1'b1 : r_starve;
      if (w_grant_i | w_grant_d) begin
        r_addr <= w_grant_d ? D_Addr : I_Addr;
        r_wdata <= w_grant_d ? D_WData : '0;
        r_size <= ~w_grant_d ? WW : D_Size == 2'b11 ? WB : D_Size;
        r_we <= w_grant_d & D_WE;
        r_uns <= D_Unsigned;
        r_is_d <= w_grant_d;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random fetch/data traffic scoreboarded against a transaction-level model with its own shadow memory
module tb_mem_arbiter;
  import mem_pkg::*;
  localparam int LIM = 4;
  localparam int MSZ = 1024;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic I_Req = 1'b0, D_Req = 1'b0, D_WE = 1'b0, D_Unsigned = 1'b0;
  logic [31:0] I_Addr = '0, D_Addr = '0, D_WData = '0;
  logic [1:0] D_Size = '0;
  logic I_Ack, D_Ack, M_W_EN, Err;
  logic [31:0] I_Data, D_RData, M_Addr, M_Data, M_RData;
  logic [1:0] M_sel;

  int vectors = 0;
  int errors = 0;

  typedef struct packed {logic is_d; logic [31:0] idata; logic [31:0] drdata; logic err;} exp_t;
  exp_t q[$];

  logic [7:0] mem [MSZ];
  logic [7:0] sh [MSZ];

  mem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(LIM)) dut (
    .CLK(CLK), .RST(RST),
    .I_Req(I_Req), .I_Addr(I_Addr), .I_Ack(I_Ack), .I_Data(I_Data),
    .D_Req(D_Req), .D_WE(D_WE), .D_Size(D_Size), .D_Unsigned(D_Unsigned),
    .D_Addr(D_Addr), .D_WData(D_WData), .D_Ack(D_Ack), .D_RData(D_RData),
    .M_Addr(M_Addr), .M_Data(M_Data), .M_W_EN(M_W_EN), .M_sel(M_sel),
    .M_RData(M_RData), .Err(Err)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] pat(int a);
    logic [31:0] f = 32'h8C010004;
    if (a >= 16 && a < 20) return f[8*(a-16)+:8];
    return 8'((a * 37 + 11) ^ (a >> 3));
  endfunction

  function automatic int nbytes(logic [1:0] sz);
    return sz == 2'b00 ? 4 : sz == 2'b01 ? 2 : 1;
  endfunction

  function automatic logic [31:0] ext(logic [31:0] w, logic [1:0] sz, logic uns);
    int n = nbytes(sz);
    longint span, v;
    if (n == 4) return w;
    span = longint'(1) << (8 * n);
    v = longint'(w) % span;
    if (!uns && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  function automatic logic misal(logic d, logic [1:0] sz, logic [31:0] a);
`ifdef MEM_ARB_ALIGN_CHECK_EN
    return !d ? a[1:0] != 0 : sz == 2'b00 ? a[1:0] != 0 : sz == 2'b01 ? a[0] : 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] memw(logic [31:0] a);
    return {mem[10'(a + 32'd3)], mem[10'(a + 32'd2)], mem[10'(a + 32'd1)], mem[10'(a)]};
  endfunction

  assign M_RData = {mem[10'(M_Addr + 32'd3)], mem[10'(M_Addr + 32'd2)], mem[10'(M_Addr + 32'd1)], mem[10'(M_Addr)]};

  // memory: sample the port mid-cycle, commit at the rising edge that ends the access
  initial begin
    logic wen;
    logic [31:0] wa, wd;
    logic [1:0] ws;
    for (int i = 0; i < MSZ; i++) mem[i] = pat(i);
    forever begin
      @(negedge CLK);
      #2;
      wen = M_W_EN; wa = M_Addr; wd = M_Data; ws = M_sel;
      @(posedge CLK);
      if (wen) for (int k = 0; k < nbytes(ws); k++) mem[10'(wa + 32'(k))] = wd[8*k+:8];
    end
  end

  // reference model: one transaction at a time, grant on a free edge, result one edge later
  initial begin
    int starve;
    logic pend, p_d, p_we, p_uns, bad;
    logic [1:0] p_sz;
    logic [31:0] p_a, p_wd, ei, ed, w;
    starve = 0; pend = 0; ei = 0; ed = 0;
    p_d = 0; p_we = 0; p_uns = 0; p_sz = 0; p_a = 0; p_wd = 0;
    for (int i = 0; i < MSZ; i++) sh[i] = pat(i);
    forever begin
      @(posedge CLK);
      if (!RST) begin
        starve = 0; pend = 0; ei = 0; ed = 0;
      end else if (pend) begin
        pend = 0;
        bad = misal(p_d, p_sz, p_a);
        if (!bad) begin
          w = {sh[10'(p_a + 32'd3)], sh[10'(p_a + 32'd2)], sh[10'(p_a + 32'd1)], sh[10'(p_a)]};
          if (!p_d) ei = w;
          else if (p_we) for (int k = 0; k < nbytes(p_sz); k++) sh[10'(p_a + 32'(k))] = p_wd[8*k+:8];
          else ed = ext(w, p_sz, p_uns);
        end
        q.push_back('{p_d, ei, ed, bad});
      end else if (I_Req || D_Req) begin
        p_d = D_Req && !(I_Req && starve == LIM);
        starve = (p_d && I_Req) ? (starve < LIM ? starve + 1 : LIM) : 0;
        p_a = p_d ? D_Addr : I_Addr;
        p_we = p_d && D_WE; p_sz = p_d ? D_Size : 2'b00; p_uns = D_Unsigned; p_wd = D_WData;
        pend = 1;
      end else starve = 0;
    end
  end

  // monitor: every ack must match the next modelled transaction, in the cycle it is due
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (I_Ack || D_Ack || q.size() > 0) begin
        vectors++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack: I_Ack=%b D_Ack=%b with no transaction due", I_Ack, D_Ack);
        end else begin
          e = q.pop_front();
          if ({I_Ack, D_Ack} !== {~e.is_d, e.is_d} || I_Data !== e.idata || D_RData !== e.drdata || Err !== e.err) begin
            errors++;
            $display("FAIL ack_check: got I_Ack=%b D_Ack=%b I_Data=%h D_RData=%h Err=%b, required I_Ack=%b D_Ack=%b I_Data=%h D_RData=%h Err=%b",
                     I_Ack, D_Ack, I_Data, D_RData, Err, ~e.is_d, e.is_d, e.idata, e.drdata, e.err);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  task automatic d_txn(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er);
    rd = '0; er = 1'b0;
    D_WE = we; D_Size = sz; D_Unsigned = uns; D_Addr = a; D_WData = wd; D_Req = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (D_Ack) begin
        D_Req = 1'b0; rd = D_RData; er = Err;
        return;
      end
    end
    D_Req = 1'b0;
    vectors++; errors++;
    $display("FAIL d_timeout: got no D_Ack in 20 cycles, required one");
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    int k, diff;
    #1000000;
    $display("FAIL watchdog: got no end of run, required one before the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic er;
    int k, diff;
    repeat (3) @(negedge CLK);
    chk("rst_flags", {28'd0, I_Ack, D_Ack, Err, M_W_EN}, 32'd0);
    chk("rst_i_data", I_Data, 32'd0);
    chk("rst_d_rdata", D_RData, 32'd0);
    chk("rst_m_addr", M_Addr, 32'd0);
    chk("rst_m_data_sel", M_Data | 32'(M_sel), 32'd0);
    RST = 1'b1;
    @(negedge CLK);
    I_Addr = 32'h10; I_Req = 1'b1;
    @(negedge CLK);
    chk("fetch_access_ack", 32'(I_Ack), 32'd0);
    chk("fetch_m_addr", M_Addr, 32'h10);
    chk("fetch_m_sel_wen", {29'd0, M_sel, M_W_EN}, 32'd0);
    @(negedge CLK);
    chk("fetch_ack", 32'(I_Ack), 32'd1);
    chk("fetch_data", I_Data, 32'h8C010004);
    I_Req = 1'b0;
    @(negedge CLK);
    chk("fetch_ack_pulse", 32'(I_Ack), 32'd0);
    d_txn(1'b1, WH, 1'b0, 32'h40, 32'h0000BEEF, rd, er);
    d_txn(1'b0, WH, 1'b0, 32'h40, 32'h0, rd, er);
    chk("half_signed", rd, 32'hFFFFBEEF);
    d_txn(1'b0, WH, 1'b1, 32'h40, 32'h0, rd, er);
    chk("half_unsigned", rd, 32'h0000BEEF);
    d_txn(1'b1, WW, 1'b0, 32'h40, 32'h12348056, rd, er);
    d_txn(1'b0, WB, 1'b0, 32'h41, 32'h0, rd, er);
    chk("byte_signed", rd, 32'hFFFFFF80);
    d_txn(1'b0, 2'b11, 1'b1, 32'h41, 32'h0, rd, er);
    chk("size11_unsigned", rd, 32'h00000080);
    D_WE = 1'b1; D_Size = WW; D_Addr = 32'h80; D_WData = 32'hDEADBEEF; D_Req = 1'b1;
    @(negedge CLK);
    chk("store_wen", 32'(M_W_EN), 32'd1);
    RST = 1'b0; D_Req = 1'b0;
    #1;
    chk("store_wen_rst", 32'(M_W_EN), 32'd0);
    @(negedge CLK);
    chk("rst_access_flags", {29'd0, D_Ack, I_Ack, Err}, 32'd0);
    chk("rst_access_addr", M_Addr, 32'd0);
    chk("rst_access_mem", memw(32'h80), {pat(131), pat(130), pat(129), pat(128)});
    RST = 1'b1;
    @(negedge CLK);
`ifdef MEM_ARB_ALIGN_CHECK_EN
    d_txn(1'b1, WW, 1'b0, 32'h42, 32'hCAFEF00D, rd, er);
    chk("misalign_err", 32'(er), 32'd1);
    chk("misalign_mem_lo", memw(32'h40), 32'h12348056);
    chk("misalign_mem_hi", memw(32'h44), {pat(71), pat(70), pat(69), pat(68)});
`else
    d_txn(1'b1, WW, 1'b0, 32'h42, 32'hCAFEF00D, rd, er);
    chk("unaligned_err", 32'(er), 32'd0);
    d_txn(1'b0, WW, 1'b0, 32'h42, 32'h0, rd, er);
    chk("unaligned_word", rd, 32'hCAFEF00D);
`endif
    D_WE = 1'b0; D_Size = WW; D_Unsigned = 1'b0; D_Addr = 32'h20; I_Addr = 32'h30;
    D_Req = 1'b1; I_Req = 1'b1;
    k = 0;
    for (int c = 0; c < 100 && k < 15; c++) begin
      @(negedge CLK);
      if (I_Ack || D_Ack) begin
        chk($sformatf("contention_%0d", k), 32'(I_Ack), 32'(k % 5 == 4));
        k++;
      end
    end
    if (k < 15) chk("contention_timeout", 32'(k), 32'd15);
    D_Req = 1'b0; I_Req = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      if (!I_Req || I_Ack) begin
        I_Req = $urandom_range(0, 2) != 0;
        I_Addr = $urandom_range(0, 1) ? 32'($urandom_range(0, 1019)) : 32'h100 + 32'($urandom_range(0, 63));
      end
      if (!D_Req || D_Ack) begin
        D_Req = $urandom_range(0, 3) != 0;
        D_WE = $urandom_range(0, 1) == 1;
        D_Size = 2'($urandom_range(0, 3));
        D_Unsigned = $urandom_range(0, 1) == 1;
        D_Addr = $urandom_range(0, 1) ? 32'($urandom_range(0, 1019)) : 32'h100 + 32'($urandom_range(0, 63));
        D_WData = $urandom;
      end
    end
    for (int c = 0; c < 50 && (I_Req || D_Req); c++) begin
      @(negedge CLK);
      if (I_Ack) I_Req = 1'b0;
      if (D_Ack) D_Req = 1'b0;
    end
    repeat (4) @(negedge CLK);
    chk("queue_drained", 32'(q.size()), 32'd0);
    diff = 0;
    for (int i = 0; i < MSZ; i++) if (mem[i] !== sh[i]) diff++;
    chk("mem_final_diff", 32'(diff), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 32, byte address width on all ports.
REQ-002 Parameter DATA_WIDTH, default 32, data width on all ports.
REQ-003 Parameter STARVE_LIMIT, default 4, number of consecutive data grants allowed while an instruction request waits.
REQ-004 CLK  input  1  clock; all state updates on its rising edge.
REQ-005 RST  input  1  reset; synchronous, active-low.
REQ-006 I_Req  input  1  instruction-fetch request; I_Addr input ADDRESS_WIDTH, fetch address.
REQ-007 I_Ack  output  1  one-cycle fetch done pulse; I_Data output DATA_WIDTH, registered fetched word.
REQ-008 D_Req  input  1  data request; D_WE input 1, 1=store, 0=load.
REQ-009 D_Size input 2: 00 word, 01 half, 10 byte, 11 treated as byte. D_Unsigned input 1: zero-extend loads.
REQ-010 D_Addr input ADDRESS_WIDTH, data address; D_WData input DATA_WIDTH, store data.
REQ-011 D_Ack  output  1  one-cycle data done pulse; D_RData output DATA_WIDTH, registered extended load result.
REQ-012 M_Addr output ADDRESS_WIDTH; M_Data output DATA_WIDTH; M_W_EN output 1; M_sel output 2; all to the memory.
REQ-013 M_RData  input  DATA_WIDTH  combinational little-endian word read at M_Addr.
REQ-014 Err  output  1  misalignment flag (see Configuration).

Function
REQ-015 FSM states IDLE and ACCESS; at most one memory access per ACCESS cycle.
REQ-016 IDLE: if any Req high, pick winner, latch its address/data/size/WE into request registers, go to ACCESS; else stay IDLE.
REQ-017 ACCESS: drive M_* from request registers; capture result at end of cycle; pulse winner's Ack in next cycle; return to IDLE.
REQ-018 Latency: Req sampled at edge t -> ACCESS in cycle t+1 -> Ack high for exactly cycle t+2.
REQ-019 Requester holds Req and inputs stable until Ack; Req high during its Ack cycle is a new request.
REQ-020 Arbitration: data wins by default; instruction wins if D_Req low, or if starvation counter equals STARVE_LIMIT.
REQ-021 Starvation counter: increments on a data grant while I_Req high; clears on instruction grant or when I_Req low in IDLE; saturates at STARVE_LIMIT.
REQ-022 Fetch: M_sel=00, M_W_EN=0; I_Data <= M_RData.
REQ-023 Store: M_sel=D_Size (11 -> 10), M_Data=D_WData, M_W_EN=1 only in ACCESS and only while RST high; D_RData unchanged.
REQ-024 Load: byte=M_RData[7:0], half=M_RData[15:0], word=M_RData; sign-extended unless D_Unsigned=1.
REQ-025 M_W_EN=0 in IDLE; M_Addr, M_Data, M_sel hold request-register values at all times.
REQ-026 I_Ack and D_Ack never high in the same cycle.

Reset
REQ-027 RST low at an edge: state IDLE, counter 0, request registers 0, I_Ack/D_Ack/Err 0, I_Data/D_RData 0.
REQ-028 RST low during ACCESS: access abandoned, no memory write, no Ack issued.

Configuration
REQ-029 Macro MEM_ARB_ALIGN_CHECK_EN defined: fetch with Addr[1:0]!=0, word data with Addr[1:0]!=0, or half data with Addr[0]!=0 is not performed (M_W_EN=0, read data register unchanged). Ack still pulses at normal latency; Err high in the same cycle.
REQ-030 Macro undefined: Err tied 0; all addresses accessed as given.

Structure
REQ-031 Shared package mem_pkg: size encodings WW=2'b00, WH=2'b01, WB=2'b10; FSM state encoding; default STARVE_LIMIT.
REQ-032 One sub-module load_extend (combinational): size, unsigned flag and word in, extended result out.

Verification
REQ-033 Fetch only: I_Req=1, I_Addr=0x10, memory word 0x8C010004 -> I_Ack in cycle t+2, I_Data=0x8C010004.
REQ-034 Store then load: store half 0xBEEF at 0x40, then signed half load at 0x40 -> D_RData=0xFFFFBEEF; unsigned -> 0x0000BEEF.
REQ-035 Signed byte load at 0x41 after word store 0x12348056 at 0x40 -> D_RData=0xFFFFFF80.
REQ-036 Contention: D_Req and I_Req held high continuously, STARVE_LIMIT=4 -> four D_Acks, then one I_Ack, pattern repeats.
REQ-037 Reset: RST low in ACCESS of a store to 0x80 -> no write at 0x80, no D_Ack, outputs at reset values next cycle.
REQ-038 MEM_ARB_ALIGN_CHECK_EN defined: word store to 0x42 -> D_Ack and Err high together, memory at 0x40..0x47 unchanged.
